// File: rtl/shift_seq_pkg.sv
// Shared types and width constants for the shift sequencer.
//   shift_mode_t : request mode encoding (matches the 2-bit in_mode field)
//   state_t      : sequencer FSM states
//   DATA_W/AMT_W/N_W : operand, request-amount and shifter-amount widths
package shift_seq_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = 5;
  localparam int N_W    = 4;

  typedef enum logic [1:0] {
    SH_LSR = 2'b00,
    SH_ASR = 2'b01,
    SH_LSL = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response handshake bundle of the shift sequencer.
//   in_valid/in_ready/in_data/in_amount/in_mode : request channel
//   out_valid/out_ready/out_data/out_passes     : result channel
//   master : the client issuing requests and consuming results
//   slave  : the sequencer
interface shift_sequencer_if;
  import shift_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amount;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [N_W-1:0]    out_passes;

  modport master (
    output in_valid, in_data, in_amount, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_passes
  );

  modport slave (
    input  in_valid, in_data, in_amount, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_passes
  );

endinterface

// File: rtl/shift_sequencer_amount_calc.sv
// Combinational amount decoder.
//   mode_i   : request mode (shift_mode_t encoding)
//   amount_i : requested shift amount 0..31
//   eff_o    : effective amount (rotate: amount mod 8, else min(amount, 8))
//   passes_o : shifter passes needed, max(1, ceil(eff / STEP_MAX))
module shift_amount_calc
  import shift_seq_pkg::*;
#(
  parameter int STEP_MAX = 7
) (
  input  logic [1:0]       mode_i,
  input  logic [AMT_W-1:0] amount_i,
  output logic [N_W-1:0]   eff_o,
  output logic [N_W-1:0]   passes_o
);

  // One extra bit so eff + STEP_MAX - 1 (at most 15) cannot wrap.
  logic [N_W:0] round_up;

  always_comb begin
    if (shift_mode_t'(mode_i) == SH_ROR) begin
      eff_o = {1'b0, amount_i[2:0]};
    end else if (amount_i >= AMT_W'(8)) begin
      // Any shift of 8 or more already flushes the whole byte.
      eff_o = N_W'(8);
    end else begin
      eff_o = amount_i[N_W-1:0];
    end

    round_up = {1'b0, eff_o} + (N_W+1)'(STEP_MAX - 1);

    // A zero amount still spends one pass with sh_n = 0.
    if (eff_o == '0) begin
      passes_o = N_W'(1);
    end else begin
      passes_o = N_W'(round_up / (N_W+1)'(STEP_MAX));
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle control stage around an external 8-bit funnel shifter.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/result handshake (slave side)
//   sh_i/sh_n/sh_ar/sh_lr/sh_rot : drive the shifter inputs
//   sh_o       : shifter result, combinational from sh_*
// A request is split into passes of at most STEP_MAX positions; each pass
// feeds the accumulator through the shifter and captures the result.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int STEP_MAX = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_sequencer_if.slave  bus,
  output logic [DATA_W-1:0] sh_i,
  output logic [N_W-1:0]    sh_n,
  output logic              sh_ar,
  output logic              sh_lr,
  output logic              sh_rot,
  input  logic [DATA_W-1:0] sh_o
);

  if (STEP_MAX < 1 || STEP_MAX > 8) begin : g_step_max_check
    $error("shift_sequencer: STEP_MAX must lie in 1..8");
  end

  localparam logic [N_W-1:0] STEP_N = N_W'(STEP_MAX);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [N_W-1:0]    rem_q, rem_d;
  shift_mode_t       mode_q, mode_d;
  logic [N_W-1:0]    pass_q, pass_d;
  logic [N_W-1:0]    target_q, target_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [N_W-1:0]    out_passes_q, out_passes_d;

  logic [N_W-1:0]    eff;
  logic [N_W-1:0]    passes;
  logic [N_W-1:0]    step;

  shift_amount_calc #(
    .STEP_MAX (STEP_MAX)
  ) u_amount_calc (
    .mode_i   (bus.in_mode),
    .amount_i (bus.in_amount),
    .eff_o    (eff),
    .passes_o (passes)
  );

  // Never step past what is left, so remaining cannot underflow.
  assign step = (rem_q > STEP_N) ? STEP_N : rem_q;

  assign sh_i   = acc_q;
  assign sh_n   = (state_q == SHIFT) ? step : '0;
  assign sh_ar  = (state_q == SHIFT) && (mode_q == SH_ASR);
  assign sh_lr  = (state_q == SHIFT) && (mode_q == SH_LSL);
  assign sh_rot = (state_q == SHIFT) && (mode_q == SH_ROR);

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_passes = out_passes_q;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    mode_d       = mode_q;
    pass_d       = pass_q;
    target_d     = target_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_passes_d = out_passes_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d    = bus.in_data;
          rem_d    = eff;
          mode_d   = shift_mode_t'(bus.in_mode);
          pass_d   = '0;
          target_d = passes;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        acc_d  = sh_o;
        rem_d  = rem_q - step;
        pass_d = pass_q + N_W'(1);
        if (rem_d == '0) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          out_data_d   = sh_o;
          out_passes_d = pass_q + N_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      rem_q        <= '0;
      mode_q       <= SH_LSR;
      pass_q       <= '0;
      target_q     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_passes_q <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      rem_q        <= rem_d;
      mode_q       <= mode_d;
      pass_q       <= pass_d;
      target_q     <= target_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_passes_q <= out_passes_d;
    end
  end

  // The pass count predicted at accept must match the passes actually run.
  a_pass_count: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == SHIFT && rem_d == '0) |-> (pass_d == target_q)
  );

endmodule

// File: tb/tb_shift_sequencer.sv
// Two sequencers (STEP_MAX 7 and 2) share one stimulus stream; each has its
// own shifter model, expectation queue and output monitor.
module tb_shift_sequencer;

  localparam int STEP_A = 7;
  localparam int STEP_B = 2;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   ready_mode;

  shift_sequencer_if ifa ();
  shift_sequencer_if ifb ();

  logic [7:0] sh_i_a, sh_o_a, sh_i_b, sh_o_b;
  logic [3:0] sh_n_a, sh_n_b;
  logic       ar_a, lr_a, rot_a, ar_b, lr_b, rot_b;

  shift_sequencer #(.STEP_MAX(STEP_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa),
    .sh_i(sh_i_a), .sh_n(sh_n_a), .sh_ar(ar_a), .sh_lr(lr_a), .sh_rot(rot_a),
    .sh_o(sh_o_a)
  );

  shift_sequencer #(.STEP_MAX(STEP_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb),
    .sh_i(sh_i_b), .sh_n(sh_n_b), .sh_ar(ar_b), .sh_lr(lr_b), .sh_rot(rot_b),
    .sh_o(sh_o_b)
  );

  // Behavioural funnel shifter standing in for the real one.
  function automatic logic [7:0] shifter(input logic [7:0] i, input logic [3:0] n,
                                          input logic ar, input logic lr, input logic rot);
    int v;
    int k;
    v = int'(i);
    k = int'(n);
    if (k > 8) k = 8;
    if (rot) begin
      k = k % 8;
      return 8'(((v >> k) | (v << (8 - k))) & 255);
    end
    if (lr) return (k >= 8) ? 8'h00 : 8'((v << k) & 255);
    if (ar) begin
      if (v >= 128) v = v - 256;
      v = v >>> k;
      return 8'(v & 255);
    end
    return (k >= 8) ? 8'h00 : 8'(v >> k);
  endfunction

  assign sh_o_a = shifter(sh_i_a, sh_n_a, ar_a, lr_a, rot_a);
  assign sh_o_b = shifter(sh_i_b, sh_n_b, ar_b, lr_b, rot_b);

  // Reference model: whole-request result straight from the mode rules.
  function automatic int ref_eff(input int m, input int a);
    if (m == 3) return a % 8;
    return (a > 8) ? 8 : a;
  endfunction

  function automatic int ref_passes(input int m, input int a, input int step);
    int e;
    e = ref_eff(m, a);
    if (e == 0) return 1;
    return (e + step - 1) / step;
  endfunction

  function automatic int ref_result(input int m, input int d, input int a);
    int s;
    int r;
    case (m)
      0: return (a >= 8) ? 0 : (d >> a);
      1: begin
        s = (d >= 128) ? d - 256 : d;
        r = (a > 8) ? 8 : a;
        s = s >>> r;
        return s & 255;
      end
      2: return (a >= 8) ? 0 : ((d << a) & 255);
      default: begin
        r = a % 8;
        return ((d >> r) | (d << (8 - r))) & 255;
      end
    endcase
  endfunction

  typedef struct {
    int data;
    int passes;
    int acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  logic [1:0] ov, ir, ordy;
  logic [7:0] od [2];
  logic [3:0] op [2];
  logic [6:0] shctl [2];
  assign ov   = {ifb.out_valid, ifa.out_valid};
  assign ir   = {ifb.in_ready, ifa.in_ready};
  assign ordy = {ifb.out_ready, ifa.out_ready};
  assign od[0] = ifa.out_data;
  assign od[1] = ifb.out_data;
  assign op[0] = ifa.out_passes;
  assign op[1] = ifb.out_passes;
  assign shctl[0] = {ar_a, lr_a, rot_a, sh_n_a};
  assign shctl[1] = {ar_b, lr_b, rot_b, sh_n_b};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Result-side ready: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    ifa.out_ready = 1'b1;
    ifb.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: begin ifa.out_ready = 1'b1; ifb.out_ready = 1'b1; end
        1: begin
          ifa.out_ready = 1'($urandom_range(0, 1));
          ifb.out_ready = ifa.out_ready;
        end
        default: begin ifa.out_ready = 1'b0; ifb.out_ready = 1'b0; end
      endcase
    end
  end

  // Monitor: pops an expectation when a result appears, then checks it holds.
  bit pend [2];
  int held_d [2];
  int held_p [2];
  int hs_cyc [2];

  initial begin
    exp_t e;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        continue;
      end
      for (int k = 0; k < 2; k++) begin
        if (pend[k]) begin
          chk($sformatf("valid_held_dut%0d", k), int'(ov[k]), 1);
          chk($sformatf("data_held_dut%0d", k), int'(od[k]), held_d[k]);
          chk($sformatf("passes_held_dut%0d", k), int'(op[k]), held_p[k]);
          chk($sformatf("in_ready_busy_dut%0d", k), int'(ir[k]), 0);
        end else if (ov[k]) begin
          if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output dut%0d actual=%02h required=none", k, od[k]);
          end else begin
            if (k == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            $display("dut%0d result data=%02h passes=%0d latency=%0d", k, od[k], op[k], cyc - e.acc);
            chk($sformatf("data_dut%0d", k), int'(od[k]), e.data);
            chk($sformatf("passes_dut%0d", k), int'(op[k]), e.passes);
            chk($sformatf("latency_dut%0d", k), cyc - e.acc, e.passes);
            chk($sformatf("in_ready_done_dut%0d", k), int'(ir[k]), 0);
            held_d[k] = e.data;
            held_p[k] = e.passes;
            pend[k] = 1'b1;
          end
        end
        if (pend[k] && ov[k] && ordy[k]) begin
          pend[k] = 1'b0;
          hs_cyc[k] = cyc + 1;
        end
        if (ir[k]) chk($sformatf("idle_shifter_ctl_dut%0d", k), int'(shctl[k]), 0);
      end
    end
  end

  task automatic set_req(input logic v, input logic [1:0] m, input logic [7:0] d, input logic [4:0] a);
    ifa.in_valid = v; ifa.in_mode = m; ifa.in_data = d; ifa.in_amount = a;
    ifb.in_valid = v; ifb.in_mode = m; ifb.in_data = d; ifb.in_amount = a;
  endtask

  // Issue one request to both DUTs so they accept on the same edge.
  task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [4:0] a,
                      input int ed, input int pa, input int pb, input bit hold,
                      output int acc);
    int n;
    exp_t e;
    n = 0;
    set_req(hold, m, d, a);
    while (!(ifa.in_ready && ifb.in_ready)) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=%0d required=<=300", n);
        set_req(1'b0, m, d, a);
        acc = -1;
        return;
      end
    end
    set_req(1'b1, m, d, a);
    @(posedge clk);
    #1;
    acc = cyc;
    e.data = ed; e.acc = cyc;
    e.passes = pa; qa.push_back(e);
    e.passes = pb; qb.push_back(e);
    set_req(1'b0, m, d, a);
  endtask

  typedef struct {
    int m;
    int d;
    int a;
    int ed;
    int pa;
    int pb;
  } dir_t;

  dir_t dir [6];
  int   acc;
  int   acc2;

  initial begin
    cyc = 0; checks = 0; errors = 0; ready_mode = 0;
    dir[0] = '{2, 'h81, 3,  'h08, 1, 2};
    dir[1] = '{1, 'h80, 20, 'hFF, 2, 4};
    dir[2] = '{3, 'h96, 13, 'hB4, 1, 3};
    dir[3] = '{0, 'h5A, 0,  'h5A, 1, 1};
    dir[4] = '{3, 'h3C, 16, 'h3C, 1, 1};
    dir[5] = '{2, 'hFF, 8,  'h00, 2, 4};

    rst_n = 1'b0;
    set_req(1'b0, 2'd0, 8'd0, 5'd0);
    #3;
    chk("reset_out_valid_a", int'(ifa.out_valid), 0);
    chk("reset_out_valid_b", int'(ifb.out_valid), 0);
    chk("reset_out_data_a", int'(ifa.out_data), 0);
    chk("reset_out_passes_b", int'(ifb.out_passes), 0);
    chk("reset_sh_n_a", int'(sh_n_a), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready_a", int'(ifa.in_ready), 1);
    chk("reset_in_ready_b", int'(ifb.in_ready), 1);

    // Directed cases, consumer always ready.
    for (int i = 0; i < 6; i++) begin
      send(2'(dir[i].m), 8'(dir[i].d), 5'(dir[i].a), dir[i].ed, dir[i].pa, dir[i].pb, 1'b0, acc);
      if (acc >= 0) begin
        chk($sformatf("first_sh_n_a_case%0d", i), int'(sh_n_a),
            (ref_eff(dir[i].m, dir[i].a) < STEP_A) ? ref_eff(dir[i].m, dir[i].a) : STEP_A);
        chk($sformatf("first_sh_n_b_case%0d", i), int'(sh_n_b),
            (ref_eff(dir[i].m, dir[i].a) < STEP_B) ? ref_eff(dir[i].m, dir[i].a) : STEP_B);
      end
    end

    // Backpressure: result stalled, second request held on the bus.
    repeat (12) @(negedge clk);
    ready_mode = 2;
    send(2'd2, 8'h81, 5'd3, 'h08, 1, 2, 1'b0, acc);
    fork
      send(2'd0, 8'hC3, 5'd2, 'h30, 1, 1, 1'b1, acc2);
      begin
        repeat (8) @(negedge clk);
        ready_mode = 0;
      end
    join
    chk("accept_after_handshake_a", acc2, hs_cyc[0] + 1);
    chk("accept_after_handshake_b", acc2, hs_cyc[1] + 1);

    // Reset during the first pass of an ASR request.
    repeat (6) @(negedge clk);
    send(2'd1, 8'h80, 5'd20, 'hFF, 2, 4, 1'b0, acc);
    #1;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk("midreset_out_valid_a", int'(ifa.out_valid), 0);
    chk("midreset_out_valid_b", int'(ifb.out_valid), 0);
    chk("midreset_in_ready_a", int'(ifa.in_ready), 1);
    chk("midreset_sh_n_b", int'(sh_n_b), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("post_reset_no_output_a", int'(ifa.out_valid), 0);
      chk("post_reset_no_output_b", int'(ifb.out_valid), 0);
      chk("post_reset_in_ready_a", int'(ifa.in_ready), 1);
    end

    // Randomised requests with random consumer stalls.
    ready_mode = 1;
    for (int i = 0; i < 60; i++) begin
      int m, d, a;
      m = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 255));
      a = int'($urandom_range(0, 31));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(2'(m), 8'(d), 5'(a), ref_result(m, d, a),
           ref_passes(m, a, STEP_A), ref_passes(m, a, STEP_B), 1'b0, acc);
    end

    ready_mode = 0;
    for (int i = 0; i < 500; i++) begin
      if (qa.size() == 0 && qb.size() == 0 && !pend[0] && !pend[1]) break;
      @(negedge clk);
    end
    chk("drain_queue_a", qa.size(), 0);
    chk("drain_queue_b", qb.size(), 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
